mem_access_unit: RTL and testbench

Memory-stage load/store front end for the pipelined RV32 core. Takes the M-stage access (address, store data, access size), enforces alignment, generates byte-lane write enables and replicated write data, and runs a req/ack handshake with a variable-latency data memory, stalling the pipeline until the access completes. It registers the raw 32-bit load word plus byte offset and write-back mode into W, where the load extension stage selects and extends the bytes.

---
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store front end: alignment check, byte-lane write generation,
// req/ack handshake with a variable-latency data memory, and the M->W register.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AluOutM,
  input  logic [31:0] StoreDataM,
  input  logic [1:0]  LoadSizeM,
  input  logic [1:0]  StoreSizeM,
  input  logic [2:0]  RegWriteM,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic [31:0] LoadDataW,
  output logic [1:0]  LoadedBytesSelectW,
  output logic [2:0]  RegWriteW,
  output logic        MisalignW,
  output logic        BusErrW
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] lat_addr;
  logic [3:0]  lat_we;
  logic [31:0] lat_wdata;
  logic        lat_load;
  logic [2:0]  lat_rw;

  logic        is_store, is_load, access, aligned, aligned_access, misaligned;
  logic [1:0]  size;
  logic [3:0]  we_m;
  logic [31:0] wdata_m;
  logic        in_wait, timeout_hit;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    is_store = (StoreSizeM != 2'b00);
    is_load  = (LoadSizeM != 2'b00) && !is_store;   // store wins an illegal overlap
    size     = is_store ? StoreSizeM : LoadSizeM;
    aligned  = 1'b1;
    case (size)
      2'b10:   aligned = ~AluOutM[0];
      2'b11:   aligned = (AluOutM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    we_m    = 4'b0000;
    wdata_m = StoreDataM;
    if (is_store) begin
      case (StoreSizeM)
        2'b01: begin
          we_m    = 4'b0001 << AluOutM[1:0];
          wdata_m = {4{StoreDataM[7:0]}};
        end
        2'b10: begin
          we_m    = AluOutM[1] ? 4'b1100 : 4'b0011;
          wdata_m = {2{StoreDataM[15:0]}};
        end
        default: begin
          we_m    = 4'b1111;
          wdata_m = StoreDataM;
        end
      endcase
    end
  end

  assign access         = is_store | is_load;
  assign aligned_access = access & aligned;
  assign misaligned     = access & ~aligned;

  assign in_wait     = (state == S_WAIT);
  assign timeout_hit = in_wait & (cnt == LAST_WAIT);

  // The timeout cycle drops the request, so an ack landing then is not honoured.
  assign mem_req   = ~rst & (in_wait ? ~timeout_hit : aligned_access);
  assign mem_addr  = in_wait ? lat_addr[31:2] : AluOutM[31:2];
  assign mem_we    = mem_req ? (in_wait ? lat_we : we_m) : 4'b0000;
  assign mem_wdata = in_wait ? lat_wdata : wdata_m;
  assign StallM    = in_wait ? (~mem_ack & ~timeout_hit) : (aligned_access & ~mem_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      cnt                <= 8'd0;
      LoadDataW          <= 32'd0;
      LoadedBytesSelectW <= 2'd0;
      RegWriteW          <= 3'd0;
      MisalignW          <= 1'b0;
      BusErrW            <= 1'b0;
    end else begin
      MisalignW <= 1'b0;
      BusErrW   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (aligned_access && !mem_ack) begin
            state <= S_WAIT;
            cnt   <= 8'd1;   // the IDLE request cycle already counts as one wait
          end
        end
        default: begin
          if (mem_ack || timeout_hit) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase

      if (StallM) begin
        RegWriteW <= 3'd0;
      end else if (in_wait) begin
        LoadedBytesSelectW <= lat_addr[1:0];
        if (timeout_hit) begin
          BusErrW   <= 1'b1;
          RegWriteW <= 3'd0;
          LoadDataW <= 32'd0;
        end else begin
          LoadDataW <= lat_load ? mem_rdata : 32'd0;
          RegWriteW <= lat_rw;
        end
      end else begin
        LoadedBytesSelectW <= AluOutM[1:0];
        if (misaligned) begin
          MisalignW <= 1'b1;
          RegWriteW <= 3'd0;
          LoadDataW <= 32'd0;
        end else begin
          LoadDataW <= is_load ? mem_rdata : 32'd0;
          RegWriteW <= RegWriteM;
        end
      end
    end
  end

  // NOTE: the latched request copy is pure datapath qualified by the FSM state, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (!in_wait && aligned_access && !mem_ack) begin
      lat_addr  <= AluOutM;
      lat_we    <= we_m;
      lat_wdata <= wdata_m;
      lat_load  <= is_load;
      lat_rw    <= RegWriteM;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: stores, waited loads, misalignment,
// timeout, reset during WAIT and back-to-back zero-wait accesses.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic [31:0] AluOutM;
  logic [31:0] StoreDataM;
  logic [1:0]  LoadSizeM;
  logic [1:0]  StoreSizeM;
  logic [2:0]  RegWriteM;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        StallM;
  logic [31:0] LoadDataW;
  logic [1:0]  LoadedBytesSelectW;
  logic [2:0]  RegWriteW;
  logic        MisalignW;
  logic        BusErrW;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .AluOutM(AluOutM), .StoreDataM(StoreDataM),
    .LoadSizeM(LoadSizeM), .StoreSizeM(StoreSizeM), .RegWriteM(RegWriteM),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .StallM(StallM), .LoadDataW(LoadDataW), .LoadedBytesSelectW(LoadedBytesSelectW),
    .RegWriteW(RegWriteW), .MisalignW(MisalignW), .BusErrW(BusErrW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] addr, input logic [31:0] sd,
                       input logic [1:0] ls, input logic [1:0] ss, input logic [2:0] rw);
    AluOutM    = addr;
    StoreDataM = sd;
    LoadSizeM  = ls;
    StoreSizeM = ss;
    RegWriteM  = rw;
  endtask

  // Advance past the next rising edge, then let outputs settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    drive(32'h0000_2000, 32'h0, 2'b11, 2'b00, 3'b010);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    tick();
    checks++; if (LoadDataW !== 32'h0) begin errors++; $display("FAIL reset_ldata: got %h expected 0", LoadDataW); end
    checks++; if (RegWriteW !== 3'b000) begin errors++; $display("FAIL reset_rw: got %b expected 000", RegWriteW); end
    checks++; if (LoadedBytesSelectW !== 2'b00) begin errors++; $display("FAIL reset_sel: got %b expected 00", LoadedBytesSelectW); end
    checks++; if ({MisalignW, BusErrW} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {MisalignW, BusErrW}); end
    rst = 1'b0;
    drive(32'h0, 32'h0, 2'b00, 2'b00, 3'b000);
    tick();
  endtask

  task automatic test_store_byte();
    // Plain ALU op first: mode passes straight through with no memory access.
    drive(32'h0000_0010, 32'h0, 2'b00, 2'b00, 3'b001);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL alu_req: got %b expected 0", mem_req); end
    tick();
    checks++; if (RegWriteW !== 3'b001) begin errors++; $display("FAIL alu_rw: got %b expected 001", RegWriteW); end

    drive(32'h0000_1003, 32'h0000_00A5, 2'b00, 2'b01, 3'b000);
    mem_ack = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sb_req: got %b expected 1", mem_req); end
    checks++; if (mem_we !== 4'b1000) begin errors++; $display("FAIL sb_we: got %b expected 1000", mem_we); end
    checks++; if (mem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", mem_wdata); end
    checks++; if (mem_addr !== 30'h400) begin errors++; $display("FAIL sb_addr: got %h expected 400", mem_addr); end
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL sb_stall: got %b expected 0", StallM); end
    tick();
    mem_ack = 1'b0;
    drive(32'h0, 32'h0, 2'b00, 2'b00, 3'b000);
    checks++; if (RegWriteW !== 3'b000) begin errors++; $display("FAIL sb_rw: got %b expected 000", RegWriteW); end
    checks++; if (LoadedBytesSelectW !== 2'b11) begin errors++; $display("FAIL sb_sel: got %b expected 11", LoadedBytesSelectW); end
    tick();
  endtask

  task automatic test_load_wait();
    int stalls = 0;
    drive(32'h0000_2000, 32'h0, 2'b11, 2'b00, 3'b010);
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      #1;
      if (StallM === 1'b1) stalls++;
      checks++; if (mem_addr !== 30'h800) begin errors++; $display("FAIL lw_addr_c%0d: got %h expected 800", c, mem_addr); end
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lw_req_c%0d: got %b expected 1", c, mem_req); end
      tick();
      if (c < 3) begin
        checks++; if (RegWriteW !== 3'b000) begin errors++; $display("FAIL lw_bubble_c%0d: got %b expected 000", c, RegWriteW); end
      end
      // Pipeline is frozen, but corrupt the M address to prove WAIT uses the latched copy.
      AluOutM = 32'hFFFF_FFFC;
    end
    checks++; if (stalls != 3) begin errors++; $display("FAIL lw_stall_cycles: got %0d expected 3", stalls); end
    mem_ack = 1'b0;
    drive(32'h0, 32'h0, 2'b00, 2'b00, 3'b000);
    checks++; if (LoadDataW !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", LoadDataW); end
    checks++; if (RegWriteW !== 3'b010) begin errors++; $display("FAIL lw_rw: got %b expected 010", RegWriteW); end
    checks++; if (LoadedBytesSelectW !== 2'b00) begin errors++; $display("FAIL lw_sel: got %b expected 00", LoadedBytesSelectW); end
    tick();
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [2];
    logic [1:0]  sizes [2];
    addrs[0] = 32'h0000_2001; sizes[0] = 2'b10;
    addrs[1] = 32'h0000_2002; sizes[1] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      drive(addrs[k], 32'h0, sizes[k], 2'b00, 3'b011);
      mem_ack = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis%0d_req: got %b expected 0", k, mem_req); end
      checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL mis%0d_stall: got %b expected 0", k, StallM); end
      tick();
      drive(32'h0, 32'h0, 2'b00, 2'b00, 3'b000);
      checks++; if (MisalignW !== 1'b1) begin errors++; $display("FAIL mis%0d_flag: got %b expected 1", k, MisalignW); end
      checks++; if (RegWriteW !== 3'b000) begin errors++; $display("FAIL mis%0d_rw: got %b expected 000", k, RegWriteW); end
      checks++; if (LoadDataW !== 32'h0) begin errors++; $display("FAIL mis%0d_data: got %h expected 0", k, LoadDataW); end
      tick();
      checks++; if (MisalignW !== 1'b0) begin errors++; $display("FAIL mis%0d_pulse: got %b expected 0", k, MisalignW); end
    end
  endtask

  task automatic test_timeout();
    int stalls = 0;
    bit done = 0;
    drive(32'h0000_3001, 32'h0, 2'b01, 2'b00, 3'b100);
    mem_ack = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (StallM === 1'b1) begin
        stalls++;
        tick();
      end else begin
        done = 1;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL to_bound: StallM still high after 40 cycles, expected release"); end
    checks++; if (stalls != 15) begin errors++; $display("FAIL to_stall_cycles: got %0d expected 15", stalls); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL to_req: got %b expected 0", mem_req); end
    tick();
    drive(32'h0, 32'h0, 2'b00, 2'b00, 3'b000);
    checks++; if (BusErrW !== 1'b1) begin errors++; $display("FAIL to_buserr: got %b expected 1", BusErrW); end
    checks++; if (RegWriteW !== 3'b000) begin errors++; $display("FAIL to_rw: got %b expected 000", RegWriteW); end
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    #1;
    checks++; if (BusErrW !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b expected 0", BusErrW); end
    checks++; if ({mem_req, StallM} !== 2'b00) begin errors++; $display("FAIL late_ack_req: got %b expected 00", {mem_req, StallM}); end
    tick();
    mem_ack = 1'b0;
    checks++; if (LoadDataW !== 32'h0) begin errors++; $display("FAIL late_ack_data: got %h expected 0", LoadDataW); end
    checks++; if (RegWriteW !== 3'b000) begin errors++; $display("FAIL late_ack_rw: got %b expected 000", RegWriteW); end
  endtask

  task automatic test_reset_in_wait();
    // Zero-wait LB leaves nonzero W state for the reset to clear.
    drive(32'h0000_4001, 32'h0, 2'b01, 2'b00, 3'b001);
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ack = 1'b0;
    drive(32'h0000_4000, 32'h0, 2'b11, 2'b00, 3'b010);
    checks++; if (LoadDataW !== 32'h5555_AAAA) begin errors++; $display("FAIL rw_pre_data: got %h expected 5555aaaa", LoadDataW); end
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rw_req: got %b expected 0", mem_req); end
    tick();
    rst = 1'b0;
    checks++; if ({LoadDataW, LoadedBytesSelectW, RegWriteW} !== 37'h0) begin errors++; $display("FAIL rw_wregs: got %h expected 0", {LoadDataW, LoadedBytesSelectW, RegWriteW}); end
    checks++; if ({MisalignW, BusErrW} !== 2'b00) begin errors++; $display("FAIL rw_err: got %b expected 00", {MisalignW, BusErrW}); end
    drive(32'h0000_5000, 32'h0, 2'b11, 2'b00, 3'b011);
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    checks++; if (mem_addr !== 30'h1400) begin errors++; $display("FAIL rw_idle_addr: got %h expected 1400", mem_addr); end
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL rw_idle_stall: got %b expected 0", StallM); end
    tick();
    mem_ack = 1'b0;
    drive(32'h0, 32'h0, 2'b00, 2'b00, 3'b000);
    checks++; if (LoadDataW !== 32'h1234_5678) begin errors++; $display("FAIL rw_post_data: got %h expected 12345678", LoadDataW); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(32'h0000_0002, 32'h0000_1234, 2'b00, 2'b10, 3'b000);
    mem_ack = 1'b1;
    mem_rdata = 32'h0;
    #1;
    checks++; if (mem_we !== 4'b1100) begin errors++; $display("FAIL sh_we: got %b expected 1100", mem_we); end
    checks++; if (mem_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata: got %h expected 12341234", mem_wdata); end
    tick();
    drive(32'h0000_0002, 32'h0, 2'b01, 2'b00, 3'b101);
    mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++; if ({mem_req, mem_we, StallM} !== 6'b1_0000_0) begin errors++; $display("FAIL lbu_bus: got %b expected 100000", {mem_req, mem_we, StallM}); end
    checks++; if (LoadedBytesSelectW !== 2'b10) begin errors++; $display("FAIL sh_sel: got %b expected 10", LoadedBytesSelectW); end
    tick();
    checks++; if (LoadDataW !== 32'hCAFE_F00D) begin errors++; $display("FAIL lbu_data: got %h expected cafef00d", LoadDataW); end
    checks++; if (LoadedBytesSelectW !== 2'b10) begin errors++; $display("FAIL lbu_sel: got %b expected 10", LoadedBytesSelectW); end
    checks++; if (RegWriteW !== 3'b101) begin errors++; $display("FAIL lbu_rw: got %b expected 101", RegWriteW); end

    // SH to the low half and an illegal load+store overlap where the SB must win.
    drive(32'h0000_0000, 32'h0000_BEEF, 2'b00, 2'b10, 3'b000);
    #1;
    checks++; if (mem_we !== 4'b0011) begin errors++; $display("FAIL sh_lo_we: got %b expected 0011", mem_we); end
    tick();
    drive(32'h0000_0001, 32'h0000_003C, 2'b11, 2'b01, 3'b000);
    #1;
    checks++; if ({mem_req, mem_we} !== 5'b1_0010) begin errors++; $display("FAIL overlap_bus: got %b expected 10010", {mem_req, mem_we}); end
    checks++; if (mem_wdata !== 32'h3C3C_3C3C) begin errors++; $display("FAIL overlap_wdata: got %h expected 3c3c3c3c", mem_wdata); end
    tick();
    mem_ack = 1'b0;
    drive(32'h0, 32'h0, 2'b00, 2'b00, 3'b000);
    checks++; if (MisalignW !== 1'b0) begin errors++; $display("FAIL overlap_mis: got %b expected 0", MisalignW); end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_wait();
    test_misalign();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
